cnn_frame_sequencer: RTL
========================

// Module: cnn_frame_sequencer
// PURPOSE
//  Frame-level controller for the image_input -> conv -> average_pooling chain.
//  On start it issues one pic_start pulse per frame for num_frames frames.
//  It counts conv and pooling output beats to detect end-of-frame.
//  It inserts a drain gap between frames, runs a stall watchdog and flags over-run beats.
// PARAMETERS
//  IMG_W      28    input image width (pixels)
//  IMG_H      28    input image height (pixels)
//  K          5     conv kernel size; CONV_N=(IMG_W-K+1)*(IMG_H-K+1)=576
//  P          2     pooling window; POOL_N=CONV_N/(P*P)=144
//  GAP_CYC    16    idle cycles between frames (line-buffer drain)
//  TIMEOUT    4096  max cycles in RUN without a conv/pool beat
//  FRM_W      8     width of frame count/index
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst_n        in   1      synchronous active-low reset
//  start        in   1      begin a batch; sampled only in IDLE
//  num_frames   in   FRM_W  frames per batch, latched on accepted start; 0 treated as 1
//  abort        in   1      abandon batch, return to IDLE
//  conv_valid   in   1      conv out_valid (monitor only)
//  pool_valid   in   1      pooling out_valid (monitor only)
//  pic_start    out  1      1-cycle pulse to image_input, one per frame
//  busy         out  1      high in every state except IDLE
//  frame_done   out  1      1-cycle pulse per completed frame
//  all_done     out  1      1-cycle pulse when batch completes
//  frame_idx    out  FRM_W  index of current frame (0-based)
//  pool_cnt     out  16     pool beats seen in current frame
//  err_timeout  out  1      sticky: watchdog expired
//  err_overrun  out  1      sticky: unexpected/excess beat
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE; all outputs 0; counters 0.
//  - All outputs are registered.
//  - FSM: IDLE, LAUNCH, RUN, GAP, DONE, ERR.
//  - IDLE: start=1 & abort=0 -> latch num_frames, frame_idx=0, go LAUNCH.
//  - LAUNCH (1 cycle): pic_start=1; clear conv/pool/watchdog counters; go RUN.
//    Latency is exactly 1 cycle from the start edge to pic_start.
//  - RUN: conv_cnt++ on conv_valid; pool_cnt++ on pool_valid.
//    Watchdog clears on any beat, else increments.
//    On the beat making pool_cnt==POOL_N: frame_done=1 the next cycle.
//      If frame_idx+1==frames, go DONE; otherwise frame_idx++ and go GAP.
//  - GAP: wait GAP_CYC cycles, then go LAUNCH (next pic_start).
//  - DONE (1 cycle): all_done=1; go IDLE; busy drops the following cycle.
//  - Watchdog: reaching TIMEOUT in RUN -> err_timeout=1, go ERR.
//    A beat in the same cycle wins and clears the watchdog.
//  - ERR: busy=1; hold until abort. start is ignored in ERR.
//  - abort (any non-IDLE state): go IDLE next cycle; no frame_done/all_done.
//    abort clears err_timeout and err_overrun.
//  - abort and start in the same IDLE cycle: abort wins, start is ignored.
//  - Overrun: set err_overrun (no state change) on any of:
//      pool_valid or conv_valid in IDLE/GAP/DONE;
//      conv_cnt already CONV_N with another conv_valid.
//  - Counters saturate and never wrap. pool_cnt is held after frame end until the next LAUNCH.
//  - rst_n asserted mid-frame: immediate return to reset state; no pulses emitted.
// TESTING
//  - num_frames=1, model emits 576 conv + 144 pool beats ->
//      one pic_start 1 cycle after start; frame_done then all_done; busy low after.
//  - num_frames=3 -> 3 pic_start pulses, each >=GAP_CYC+1 cycles after the prior frame_done;
//      frame_idx 0,1,2; single all_done.
//  - Pool stream stops at beat 100 -> err_timeout=1 exactly 4096 cycles after the last beat;
//      state ERR; abort clears it; busy=0.
//  - pool_valid pulse while IDLE -> err_overrun=1; state stays IDLE; no pic_start.
//  - start & abort same cycle in IDLE -> no pic_start.
//      abort at beat 50 of frame 2 of 3 -> IDLE, no all_done.
//  - num_frames=0 -> behaves as 1 frame.
//      rst_n low mid-RUN -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/cnn_frame_sequencer.sv
// rtl/cnn_frame_sequencer.sv - frame launch, end-of-frame detection and watchdog for the conv/pool chain
module cnn_frame_sequencer #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int K       = 5,
  parameter int P       = 2,
  parameter int GAP_CYC = 16,
  parameter int TIMEOUT = 4096,
  parameter int FRM_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [FRM_W-1:0] num_frames,
  input  logic             abort,
  input  logic             conv_valid,
  input  logic             pool_valid,
  output logic             pic_start,
  output logic             busy,
  output logic             frame_done,
  output logic             all_done,
  output logic [FRM_W-1:0] frame_idx,
  output logic [15:0]      pool_cnt,
  output logic             err_timeout,
  output logic             err_overrun
);

  localparam int CONV_N = (IMG_W - K + 1) * (IMG_H - K + 1);
  localparam int POOL_N = CONV_N / (P * P);
  localparam logic [15:0] CONV_FULL = 16'(CONV_N);
  localparam logic [15:0] POOL_LAST = 16'(POOL_N - 1);
  localparam logic [15:0] GAP_END   = 16'(GAP_CYC);
  localparam logic [31:0] WD_LAST   = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_GAP, S_DONE, S_ERR} state_t;

  state_t           state_q, state_d;
  logic [FRM_W-1:0] frames_q;
  logic [15:0]      conv_cnt_q;
  logic [15:0]      gap_cnt_q;
  logic [31:0]      wd_q;

  logic in_run, beat, pool_hit, last_frame, wd_expire, overrun_set;
  logic pic_start_d, busy_d, frame_done_d, all_done_d, err_timeout_d, err_overrun_d;

  assign in_run      = (state_q == S_RUN);
  assign beat        = conv_valid | pool_valid;
  assign pool_hit    = in_run && pool_valid && (pool_cnt == POOL_LAST);
  assign last_frame  = ((frame_idx + FRM_W'(1)) == frames_q);
  // A beat in the expiring cycle rescues the frame, so only a silent cycle can expire.
  assign wd_expire   = in_run && !beat && (wd_q == WD_LAST);
  assign overrun_set = (((state_q == S_IDLE) || (state_q == S_GAP) || (state_q == S_DONE)) && beat)
                     || (in_run && conv_valid && (conv_cnt_q == CONV_FULL));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides everything outside IDLE
  always_comb begin
    state_d = state_q;
    if ((state_q != S_IDLE) && abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start && !abort) state_d = S_LAUNCH;
        S_LAUNCH: state_d = S_RUN;
        S_RUN: begin
          if (pool_hit)       state_d = last_frame ? S_DONE : S_GAP;
          else if (wd_expire) state_d = S_ERR;
        end
        S_GAP:    if (gap_cnt_q == GAP_END) state_d = S_LAUNCH;
        S_DONE:   state_d = S_IDLE;
        S_ERR:    state_d = S_ERR;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs
  always_comb begin
    pic_start_d   = (state_d == S_LAUNCH);
    busy_d        = (state_d != S_IDLE);
    frame_done_d  = pool_hit && !abort;
    all_done_d    = (state_q == S_DONE) && !abort;
    err_timeout_d = abort ? 1'b0 : (err_timeout | wd_expire);
    err_overrun_d = abort ? 1'b0 : (err_overrun | overrun_set);
  end

  // Output registers, batch bookkeeping and saturating beat/idle counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pic_start   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      all_done    <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      frame_idx   <= '0;
      pool_cnt    <= '0;
      frames_q    <= '0;
      conv_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      wd_q        <= '0;
    end else begin
      pic_start   <= pic_start_d;
      busy        <= busy_d;
      frame_done  <= frame_done_d;
      all_done    <= all_done_d;
      err_timeout <= err_timeout_d;
      err_overrun <= err_overrun_d;
      gap_cnt_q   <= (state_q == S_GAP) ? gap_cnt_q + 16'd1 : 16'd0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            frames_q  <= (num_frames == '0) ? FRM_W'(1) : num_frames;
            frame_idx <= '0;
          end
        end
        S_LAUNCH: begin
          conv_cnt_q <= '0;
          pool_cnt   <= '0;
          wd_q       <= '0;
        end
        S_RUN: begin
          if (conv_valid && (conv_cnt_q != CONV_FULL)) conv_cnt_q <= conv_cnt_q + 16'd1;
          if (pool_valid && (pool_cnt != 16'hFFFF))    pool_cnt   <= pool_cnt + 16'd1;
          if (beat)                  wd_q <= '0;
          else if (wd_q != WD_LAST)  wd_q <= wd_q + 32'd1;
          if (pool_hit && !last_frame) frame_idx <= frame_idx + FRM_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
